// File: rtl/red_pitaya_pwm_dither.sv
// red_pitaya_pwm_dither
// Turns a {duty, seq} configuration word into a 1-bit PWM stream for an
// external RC-filtered DAC. The base period is 2**DUTY_W clocks. Each period's
// duty is raised by one slot when the seq bit for that period is set. seq is
// played LSB first over a frame of SEQ_W periods, so the frame-average
// resolution is 1/(SEQ_W * 2**DUTY_W) of full scale.
// A new cfg word is taken only at frame boundaries, so the output never glitches.
//
// Ports
//   clk_i      in   clock
//   rstn_i     in   asynchronous active-low reset
//   en_i       in   run enable; 0 = idle with the output held low
//   cfg_i      in   {duty[DUTY_W-1:0], seq[SEQ_W-1:0]}
//   pwm_o      out  registered PWM output
//   period_o   out  1-cycle pulse aligned with the last slot of each period
//   frame_o    out  1-cycle pulse aligned with the last slot of each frame
//   cfg_act_o  out  cfg word currently being played
//
// state  | meaning
// S_IDLE | en_i=0: counters cleared, shadow follows cfg_i, outputs low
// S_RUN  | en_i=1: slot counter running, shadow reloaded at frame end only
module red_pitaya_pwm_dither #(
  parameter int DUTY_W = 8,
  parameter int SEQ_W  = 16,
  parameter int CCW    = DUTY_W + SEQ_W
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           en_i,
  input  logic [CCW-1:0] cfg_i,
  output logic           pwm_o,
  output logic           period_o,
  output logic           frame_o,
  output logic [CCW-1:0] cfg_act_o
);

  localparam int IDX_W = $clog2(SEQ_W);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state;
  logic [DUTY_W-1:0] cnt;
  logic [IDX_W-1:0]  idx;
  logic [CCW-1:0]    cfg_r;
  logic [DUTY_W-1:0] duty;
  logic [SEQ_W-1:0]  seq;
  logic [DUTY_W:0]   thr;
  logic              cnt_last;
  logic              idx_last;

  // The mode follows en_i directly, so a disable takes effect on the very next edge.
  assign state = en_i ? S_RUN : S_IDLE;

  assign duty = cfg_r[CCW-1:SEQ_W];
  assign seq  = cfg_r[SEQ_W-1:0];

  // The threshold is one bit wider than the counter. With duty=max and the
  // dither bit set, thr reaches 2**DUTY_W, so the output stays high for the
  // whole period.
  assign thr = {1'b0, duty} + {{DUTY_W{1'b0}}, seq[idx]};

  assign cnt_last = (cnt == {DUTY_W{1'b1}});
  assign idx_last = (idx == IDX_W'(SEQ_W - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt      <= '0;
      idx      <= '0;
      cfg_r    <= '0;
      pwm_o    <= 1'b0;
      period_o <= 1'b0;
      frame_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          idx      <= '0;
          cfg_r    <= cfg_i;
          pwm_o    <= 1'b0;
          period_o <= 1'b0;
          frame_o  <= 1'b0;
        end
        S_RUN: begin
          cnt      <= cnt + 1'b1;
          pwm_o    <= ({1'b0, cnt} < thr);
          period_o <= cnt_last;
          frame_o  <= cnt_last && idx_last;
          if (cnt_last) begin
            idx <= idx_last ? '0 : idx + 1'b1;
            if (idx_last) begin
              cfg_r <= cfg_i;
            end
          end
        end
        default: begin
          cnt <= '0;
          idx <= '0;
        end
      endcase
    end
  end

  assign cfg_act_o = cfg_r;

endmodule

// File: tb/tb_red_pitaya_pwm_dither.sv
// tb_red_pitaya_pwm_dither
// Self-checking bench for red_pitaya_pwm_dither.
//
// Expected per-period waveforms are built slot by slot from the plain
// definition of the output: a slot is high while its position in the period
// is below duty plus the seq bit of that period. Each waveform is pushed to a
// queue and compared with the observed period once it completes. Frame-average
// high time is also checked against 16*duty + popcount(seq).
module tb_red_pitaya_pwm_dither;

  logic        clk_i;
  logic        rstn_i;
  logic        en_i;
  logic [23:0] cfg_i;
  logic        pwm_o;
  logic        period_o;
  logic        frame_o;
  logic [23:0] cfg_act_o;

  red_pitaya_pwm_dither dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .en_i      (en_i),
    .cfg_i     (cfg_i),
    .pwm_o     (pwm_o),
    .period_o  (period_o),
    .frame_o   (frame_o),
    .cfg_act_o (cfg_act_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [255:0] pwm;
    logic [255:0] per;
    logic [255:0] frm;
    logic [23:0]  cfg_first;
    logic [23:0]  cfg_last;
  } period_t;

  period_t     exp_q[$];
  period_t     exp_acc;
  period_t     obs_acc;
  int          n_checks;
  int          n_pass;
  int          slot_k;
  int          frame_hi;
  logic [23:0] fcfg;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Put the DUT in idle with the given cfg for one edge, then enable it.
  // The model restarts at slot 0 with that cfg.
  task automatic start(input logic [23:0] cfg);
    en_i  = 1'b0;
    cfg_i = cfg;
    @(posedge clk_i);
    @(negedge clk_i);
    en_i     = 1'b1;
    fcfg     = cfg;
    slot_k   = 0;
    frame_hi = 0;
    exp_acc  = '0;
    obs_acc  = '0;
    exp_q.delete();
  endtask

  // Play one slot. The expectation is formed before the edge, the output is
  // sampled on the following falling edge, and completed periods are compared.
  task automatic cycle_chk();
    int          cnt_e;
    int          p_e;
    int          thr_e;
    logic        e_pwm;
    logic        e_per;
    logic        e_frm;
    logic [23:0] e_cfg;
    period_t     e;
    int          exp_hi;
    cnt_e = slot_k % 256;
    p_e   = (slot_k / 256) % 16;
    thr_e = int'(fcfg[23:16]) + int'(fcfg[p_e]);
    e_pwm = (cnt_e < thr_e);
    e_per = (cnt_e == 255);
    e_frm = (cnt_e == 255) && (p_e == 15);
    e_cfg = e_frm ? cfg_i : fcfg;
    exp_acc.pwm[cnt_e] = e_pwm;
    exp_acc.per[cnt_e] = e_per;
    exp_acc.frm[cnt_e] = e_frm;
    if (cnt_e == 0) exp_acc.cfg_first = e_cfg;
    if (cnt_e == 255) begin
      exp_acc.cfg_last = e_cfg;
      exp_q.push_back(exp_acc);
      exp_acc = '0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    obs_acc.pwm[cnt_e] = pwm_o;
    obs_acc.per[cnt_e] = period_o;
    obs_acc.frm[cnt_e] = frame_o;
    if (cnt_e == 0) obs_acc.cfg_first = cfg_act_o;
    if (pwm_o === 1'b1) frame_hi++;
    if (cnt_e == 255) begin
      obs_acc.cfg_last = cfg_act_o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_acc.pwm !== e.pwm)
        $display("FAIL period_pwm slot=%0d got %h required %h", slot_k, obs_acc.pwm, e.pwm);
      else n_pass++;
      n_checks++;
      if (obs_acc.per !== e.per)
        $display("FAIL period_pulse slot=%0d got %h required %h", slot_k, obs_acc.per, e.per);
      else n_pass++;
      n_checks++;
      if (obs_acc.frm !== e.frm)
        $display("FAIL frame_pulse slot=%0d got %h required %h", slot_k, obs_acc.frm, e.frm);
      else n_pass++;
      n_checks++;
      if (obs_acc.cfg_first !== e.cfg_first)
        $display("FAIL cfg_act_first slot=%0d got %h required %h", slot_k, obs_acc.cfg_first, e.cfg_first);
      else n_pass++;
      n_checks++;
      if (obs_acc.cfg_last !== e.cfg_last)
        $display("FAIL cfg_act_last slot=%0d got %h required %h", slot_k, obs_acc.cfg_last, e.cfg_last);
      else n_pass++;
      obs_acc = '0;
    end
    if (e_frm) begin
      exp_hi = 16 * int'(fcfg[23:16]) + $countones(fcfg[15:0]);
      n_checks++;
      if (frame_hi !== exp_hi)
        $display("FAIL frame_high_count cfg=%h got %0d required %0d", fcfg, frame_hi, exp_hi);
      else n_pass++;
      frame_hi = 0;
      fcfg = e_cfg;
    end
    slot_k++;
  endtask

  task automatic run_slots(input int n);
    for (int i = 0; i < n; i++) cycle_chk();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    en_i   = 1'b0;
    cfg_i  = 24'h123456;
    #3;
    n_checks++;
    if ({pwm_o, period_o, frame_o} !== 3'b000)
      $display("FAIL reset_flags got %b required 000", {pwm_o, period_o, frame_o});
    else n_pass++;
    n_checks++;
    if (cfg_act_o !== 24'h0) $display("FAIL reset_cfg_act got %h required 000000", cfg_act_o);
    else n_pass++;
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({pwm_o, period_o, frame_o, cfg_act_o} !== 27'h0)
      $display("FAIL reset_held got %h required 0", {pwm_o, period_o, frame_o, cfg_act_o});
    else n_pass++;
    rstn_i = 1'b1;
  endtask

  task automatic test_half();
    start(24'h800000);
    run_slots(17 * 256);
  endtask

  task automatic test_dither();
    start(24'h400001);
    run_slots(16 * 256);
  endtask

  task automatic test_extremes();
    start(24'hFFFFFF);
    run_slots(2 * 256);
    start(24'h000000);
    run_slots(2 * 256);
    start(24'h00FFFF);
    run_slots(2 * 256);
  endtask

  task automatic test_cfg_switch();
    start(24'h800000);
    run_slots(5 * 256);
    cfg_i = 24'h200000;
    run_slots(13 * 256);
  endtask

  task automatic test_disable();
    start(24'h800000);
    run_slots(50);
    n_checks++;
    if (pwm_o !== 1'b1) $display("FAIL pre_disable_pwm got %b required 1", pwm_o);
    else n_pass++;
    en_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({pwm_o, period_o, frame_o} !== 3'b000)
      $display("FAIL disable_next_edge got %b required 000", {pwm_o, period_o, frame_o});
    else n_pass++;
    n_checks++;
    if (cfg_act_o !== 24'h800000) $display("FAIL idle_cfg_act got %h required 800000", cfg_act_o);
    else n_pass++;
    start(24'h100000);
    run_slots(2 * 256);
  endtask

  task automatic test_async_reset();
    int hi_seen;
    start(24'hFFFFFF);
    run_slots(10);
    n_checks++;
    if (pwm_o !== 1'b1) $display("FAIL pre_reset_pwm got %b required 1", pwm_o);
    else n_pass++;
    @(posedge clk_i);
    #2;
    rstn_i = 1'b0;
    en_i   = 1'b0;
    cfg_i  = 24'h0;
    #1;
    n_checks++;
    if ({pwm_o, period_o, frame_o} !== 3'b000)
      $display("FAIL async_reset_flags got %b required 000", {pwm_o, period_o, frame_o});
    else n_pass++;
    n_checks++;
    if (cfg_act_o !== 24'h0) $display("FAIL async_reset_cfg_act got %h required 000000", cfg_act_o);
    else n_pass++;
    @(negedge clk_i);
    rstn_i = 1'b1;
    hi_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if ({pwm_o, period_o, frame_o} !== 3'b000 || cfg_act_o !== 24'h0) hi_seen++;
    end
    n_checks++;
    if (hi_seen !== 0) $display("FAIL post_reset_idle got %0d active cycles required 0", hi_seen);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    slot_k   = 0;
    frame_hi = 0;
    fcfg     = '0;
    exp_acc  = '0;
    obs_acc  = '0;
    test_reset();
    test_half();
    test_dither();
    test_extremes();
    test_cfg_switch();
    test_disable();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
